// File: rtl/comp_1_bit.sv
// Registered 1-bit magnitude comparator with optional saturating event counters.
// Define COMP_1_BIT_STATS_EN to build the gt/eq/le counters and clr_cnt logic.
module comp_1_bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             A,
    input  logic             B,
    input  logic             clr_cnt,
    output logic             Eq,
    output logic             Le,
    output logic             Gt,
    output logic             valid,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] le_cnt
);

    logic a_gt_b;
    logic a_eq_b;
    logic a_lt_b;

    assign a_gt_b = A & ~B;
    assign a_eq_b = ~(A ^ B);
    assign a_lt_b = ~A & B;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            Gt    <= 1'b0;
            Eq    <= 1'b0;
            Le    <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                Gt <= a_gt_b;
                Eq <= a_eq_b;
                Le <= a_lt_b;
            end
        end
    end

`ifdef COMP_1_BIT_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear beats a coincident sample; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            gt_cnt <= '0;
            eq_cnt <= '0;
            le_cnt <= '0;
        end else if (en) begin
            if (a_gt_b && gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + 1'b1;
            if (a_eq_b && eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + 1'b1;
            if (a_lt_b && le_cnt != CNT_MAX) le_cnt <= le_cnt + 1'b1;
        end
    end
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign gt_cnt         = '0;
    assign eq_cnt         = '0;
    assign le_cnt         = '0;
`endif

endmodule

// File: tb/tb_comp_1_bit.sv
// Directed self-checking bench for comp_1_bit; two instances (CNT_W=8 and CNT_W=2)
// share stimulus so counting and saturation are exercised in the same run.
module tb_comp_1_bit;

`ifdef COMP_1_BIT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic clr_cnt = 1'b0;

    logic       eq8, le8, gt8, valid8;
    logic [7:0] gtc8, eqc8, lec8;
    logic       eq2, le2, gt2, valid2;
    logic [1:0] gtc2, eqc2, lec2;

    int checks = 0;
    int failures = 0;

    // Reference counters: index 0 = gt, 1 = eq, 2 = le.
    int m8[3];
    int m2[3];

    comp_1_bit #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .A(a), .B(b), .clr_cnt(clr_cnt),
        .Eq(eq8), .Le(le8), .Gt(gt8), .valid(valid8),
        .gt_cnt(gtc8), .eq_cnt(eqc8), .le_cnt(lec8)
    );

    comp_1_bit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .A(a), .B(b), .clr_cnt(clr_cnt),
        .Eq(eq2), .Le(le2), .Gt(gt2), .valid(valid2),
        .gt_cnt(gtc2), .eq_cnt(eqc2), .le_cnt(lec2)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] e8(input int i);
        return STATS ? 8'(m8[i]) : 8'd0;
    endfunction

    function automatic logic [1:0] e2(input int i);
        return STATS ? 2'(m2[i]) : 2'd0;
    endfunction

    // Drive one edge, then update the counter model; outputs are read 1 time unit later.
    task automatic step(input logic r, input logic e, input logic ai, input logic bi,
                        input logic c);
        int idx;
        rst = r; en = e; a = ai; b = bi; clr_cnt = c;
        @(posedge clk);
        #1;
        idx = (ai & ~bi) ? 0 : ((ai == bi) ? 1 : 2);
        if (r || c) begin
            for (int i = 0; i < 3; i++) begin
                m8[i] = 0;
                m2[i] = 0;
            end
        end else if (e) begin
            if (m8[idx] < 255) m8[idx]++;
            if (m2[idx] < 3) m2[idx]++;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if ({gt8, eq8, le8, valid8} !== 4'b0000 || {gt2, eq2, le2, valid2} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_flags cyc%0d got8=%b got2=%b exp=0000", k,
                         {gt8, eq8, le8, valid8}, {gt2, eq2, le2, valid2});
            end
            checks++;
            if ({gtc8, eqc8, lec8} !== 24'd0 || {gtc2, eqc2, lec2} !== 6'd0) begin
                failures++;
                $display("FAIL reset_cnt cyc%0d got8=%h got2=%b exp=0", k,
                         {gtc8, eqc8, lec8}, {gtc2, eqc2, lec2});
            end
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] ab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [2:0] exp [4] = '{3'b010, 3'b001, 3'b100, 3'b010};
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, ab[k][1], ab[k][0], 1'b0);
            checks++;
            if ({gt8, eq8, le8, valid8} !== {exp[k], 1'b1}) begin
                failures++;
                $display("FAIL truth_ab%b got=%b exp=%b", ab[k], {gt8, eq8, le8, valid8},
                         {exp[k], 1'b1});
            end
            checks++;
            if ({gtc8, eqc8, lec8} !== {e8(0), e8(1), e8(2)}) begin
                failures++;
                $display("FAIL truth_cnt_ab%b got=%h exp=%h", ab[k], {gtc8, eqc8, lec8},
                         {e8(0), e8(1), e8(2)});
            end
        end
    endtask

    task automatic test_hold();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({gt8, eq8, le8, valid8} !== 4'b1001) begin
            failures++;
            $display("FAIL hold_load got=%b exp=1001", {gt8, eq8, le8, valid8});
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if ({gt8, eq8, le8, valid8} !== 4'b1000) begin
                failures++;
                $display("FAIL hold_cyc%0d got=%b exp=1000", k, {gt8, eq8, le8, valid8});
            end
            checks++;
            if ({gtc8, eqc8, lec8} !== {e8(0), e8(1), e8(2)}) begin
                failures++;
                $display("FAIL hold_cnt_cyc%0d got=%h exp=%h", k, {gtc8, eqc8, lec8},
                         {e8(0), e8(1), e8(2)});
            end
        end
    endtask

    task automatic test_counting();
        // 5 x A>B, 3 x A==B (mixed 00/11), 2 x A<B, back to back.
        logic [1:0] ab [10] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11,
                                2'b10, 2'b01, 2'b10, 2'b00};
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({gtc8, eqc8, lec8} !== 24'd0) begin
            failures++;
            $display("FAIL count_clear got=%h exp=0", {gtc8, eqc8, lec8});
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, ab[k][1], ab[k][0], 1'b0);
            checks++;
            if ({gt8, eq8, le8, valid8} !==
                {ab[k][1] & ~ab[k][0], ab[k][1] ~^ ab[k][0], ~ab[k][1] & ab[k][0], 1'b1}) begin
                failures++;
                $display("FAIL count_flags_%0d got=%b ab=%b", k, {gt8, eq8, le8, valid8}, ab[k]);
            end
        end
        checks++;
        if ({gtc8, eqc8, lec8} !== (STATS ? {8'd5, 8'd3, 8'd2} : 24'd0)) begin
            failures++;
            $display("FAIL count_totals got=%0d/%0d/%0d exp=%0d/%0d/%0d", gtc8, eqc8, lec8,
                     STATS ? 5 : 0, STATS ? 3 : 0, STATS ? 2 : 0);
        end
        checks++;
        if ({gtc2, eqc2, lec2} !== {e2(0), e2(1), e2(2)}) begin
            failures++;
            $display("FAIL count_sat2 got=%b exp=%b", {gtc2, eqc2, lec2}, {e2(0), e2(1), e2(2)});
        end
    endtask

    task automatic test_saturation_clear();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, k[0], k[0], 1'b0);
            checks++;
            if (eqc2 !== (STATS ? 2'((k + 1 > 3) ? 3 : k + 1) : 2'd0)) begin
                failures++;
                $display("FAIL sat_eq_%0d got=%0d exp=%0d", k, eqc2,
                         STATS ? ((k + 1 > 3) ? 3 : k + 1) : 0);
            end
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({eqc2, gtc2, lec2, eqc8} !== 14'd0) begin
            failures++;
            $display("FAIL clr_wins got eq2=%0d eq8=%0d exp=0", eqc2, eqc8);
        end
        checks++;
        if ({gt2, eq2, le2, valid2} !== 4'b0101) begin
            failures++;
            $display("FAIL clr_flags got=%b exp=0101", {gt2, eq2, le2, valid2});
        end
    endtask

    task automatic test_midstream_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({gt8, eq8, le8, valid8, gtc8, eqc8, lec8} !== 28'd0) begin
            failures++;
            $display("FAIL mid_reset got flags=%b cnt=%h exp=0", {gt8, eq8, le8, valid8},
                     {gtc8, eqc8, lec8});
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({gt8, eq8, le8, valid8} !== 4'b0011) begin
            failures++;
            $display("FAIL post_reset got=%b exp=0011", {gt8, eq8, le8, valid8});
        end
        checks++;
        if ({gtc8, eqc8, lec8} !== (STATS ? {8'd0, 8'd0, 8'd1} : 24'd0)) begin
            failures++;
            $display("FAIL post_reset_cnt got=%h", {gtc8, eqc8, lec8});
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({gt8, eq8, le8, valid8} !== 4'b0010) begin
            failures++;
            $display("FAIL valid_drop got=%b exp=0010", {gt8, eq8, le8, valid8});
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m8[i] = 0;
            m2[i] = 0;
        end
        test_reset();
        test_truth_table();
        test_hold();
        test_counting();
        test_saturation_clear();
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comp_1_bit.md
COMP_1_BIT -- requirements
Module: comp_1_bit

Interface
REQ-001 Parameter CNT_W, default 8, width of each event counter; legal range 2..32.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port en  input  1  sample enable; A/B compared only on edges where en=1.
REQ-006 Port A  input  1  first operand.
REQ-007 Port B  input  1  second operand.
REQ-008 Port clr_cnt  input  1  synchronous clear of all event counters.
REQ-009 Port Eq  output  1  registered flag, A equal to B.
REQ-010 Port Le  output  1  registered flag, A less than B (A=0, B=1).
REQ-011 Port Gt  output  1  registered flag, A greater than B (A=1, B=0).
REQ-012 Port valid  output  1  high for one cycle after each enabled sample.
REQ-013 Port gt_cnt  output  CNT_W  count of enabled samples with A>B.
REQ-014 Port eq_cnt  output  CNT_W  count of enabled samples with A==B.
REQ-015 Port le_cnt  output  CNT_W  count of enabled samples with A<B.

Function
REQ-016 On a rising edge with rst=0 and en=1, the block SHALL load Gt=A&~B, Eq=~(A^B) and Le=~A&B; latency is exactly 1 cycle.
REQ-017 After any enabled sample, exactly one of Gt, Eq and Le SHALL be 1.
REQ-018 On a rising edge with en=0, Gt/Eq/Le SHALL hold their previous values.
REQ-019 valid SHALL be the registered copy of en; it is 1 exactly one cycle after each edge where en=1 (and rst=0).
REQ-020 With en held high, the outputs SHALL track the inputs every cycle with 1-cycle delay and no bubbles.
REQ-021 On each enabled sample, the counter matching the comparison result SHALL increment by 1; the other counters hold.
REQ-022 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 clr_cnt=1 SHALL zero all three counters on that edge; when clr_cnt and an enabled sample coincide, clear wins and the sample is not counted; Gt/Eq/Le/valid still update normally.
REQ-024 A and B SHALL be treated as unsigned single bits; no X-propagation handling is required.

Reset
REQ-025 On an edge with rst=1, Gt=0, Eq=0, Le=0, valid=0 and all counters=0, regardless of en and clr_cnt.
REQ-026 If rst is asserted mid-stream, the sample presented on that edge SHALL be discarded; the first enabled edge after rst deasserts produces a valid result.

Configuration
REQ-027 Macro COMP_1_BIT_STATS_EN: when defined, the event counters and clr_cnt logic SHALL be compiled in as specified in REQ-021..REQ-023.
REQ-028 When COMP_1_BIT_STATS_EN is not defined, gt_cnt/eq_cnt/le_cnt SHALL remain present and tied to constant 0, and clr_cnt SHALL be ignored; comparator behaviour is unchanged.

Verification
REQ-029 Reset: rst=1 for 2 cycles with en=1, A=1, B=0 -> Gt=Eq=Le=0, valid=0, counters 0.
REQ-030 Exhaustive truth table: en=1, (A,B)=00,01,10,11 on consecutive edges -> next cycles (Gt,Eq,Le)=010,001,100,010, valid=1 each cycle.
REQ-031 Hold: sample A=1,B=0, then en=0 with A=0,B=1 for 3 cycles -> Gt stays 1, valid=0 during hold.
REQ-032 Counting (macro defined, CNT_W=8): 5 samples A>B, 3 equal, 2 A<B -> gt_cnt=5, eq_cnt=3, le_cnt=2.
REQ-033 Saturation/clear (macro defined, CNT_W=2): 5 samples A==B -> eq_cnt=3; then clr_cnt=1 together with an A==B sample -> eq_cnt=0, Eq=1.
REQ-034 Macro undefined: repeat REQ-032 stimulus -> all counters 0, comparator outputs identical to REQ-030.
